// File: rtl/i2s_tx_if.sv
// Sample-side and I2S pin bundle for the i2s_tx transmitter.
// The transmitter uses the slave modport; the sample source/DAC side uses master.
interface i2s_tx_if;
  logic [15:0] left_in;
  logic [15:0] right_in;
  logic        mute;
  logic        sample_req;
  logic        i2s_bck;
  logic        i2s_lrck;
  logic        i2s_data;

  modport master (
    output left_in, right_in, mute,
    input  sample_req, i2s_bck, i2s_lrck, i2s_data
  );

  modport slave (
    input  left_in, right_in, mute,
    output sample_req, i2s_bck, i2s_lrck, i2s_data
  );
endinterface

// File: rtl/i2s_tx.sv
// I2S stereo transmitter: 16-bit samples, 32-bit frames, BCLK derived from clk.
// Define I2S_TX_LJ_EN for left-justified output (no 1-BCLK data delay).
module i2s_tx #(
  parameter int BCK_DIV = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  i2s_tx_if.slave  bus
);

  localparam int DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BCK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bit_cnt;
  logic [31:0]      frame;
  logic             bck_q;
  logic             lrck_q;
  logic             data_q;
  logic             sample_req_q;
`ifndef I2S_TX_LJ_EN
  logic             delay_q;
`endif

  logic        fall;
  logic [4:0]  next_k;
  logic [31:0] latch_word;
  logic        lj_bit;

  // At k=0 the bit comes from the word being latched on this same edge.
  always_comb begin
    fall       = 1'b0;
    next_k     = 5'd0;
    latch_word = 32'd0;
    lj_bit     = 1'b0;
    fall       = (div_cnt == DIV_MAX) && bck_q;
    next_k     = bit_cnt + 5'd1;
    latch_word = bus.mute ? 32'd0 : {bus.left_in, bus.right_in};
    lj_bit     = (next_k == 5'd0) ? latch_word[31] : frame[5'd31 - next_k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt      <= '0;
      bit_cnt      <= 5'd31;
      frame        <= 32'd0;
      bck_q        <= 1'b0;
      lrck_q       <= 1'b0;
      data_q       <= 1'b0;
      sample_req_q <= 1'b0;
`ifndef I2S_TX_LJ_EN
      delay_q      <= 1'b0;
`endif
    end else begin
      sample_req_q <= 1'b0;
      if (div_cnt == DIV_MAX) begin
        div_cnt <= '0;
        bck_q   <= ~bck_q;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      // Everything serial advances on the BCLK falling edge.
      if (fall) begin
        bit_cnt <= next_k;
        lrck_q  <= next_k[4];
        if (next_k == 5'd0) begin
          frame        <= latch_word;
          sample_req_q <= 1'b1;
        end
`ifdef I2S_TX_LJ_EN
        data_q  <= lj_bit;
`else
        data_q  <= delay_q;
        delay_q <= lj_bit;
`endif
      end
    end
  end

  assign bus.i2s_bck    = bck_q;
  assign bus.i2s_lrck   = lrck_q;
  assign bus.i2s_data   = data_q;
  assign bus.sample_req = sample_req_q;

endmodule
